// File: rtl/jts16b_trackball_feed.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : jts16b_trackball_feed                                         |
// | Desc     : Mouse/joystick to per-player signed 8-bit axis deltas, held   |
// |            for each 64-line cabinet window with residue carried over.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module jts16b_trackball_feed #(
  parameter int         PEND_W   = 12,
  parameter logic [7:0] JOY_STEP = 8'd24,
  parameter bit         INVERT_Y = 1'b1
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        LHBL,
  input  logic        mouse_strobe,
  input  logic [8:0]  mouse_dx,
  input  logic [8:0]  mouse_dy,
  input  logic [1:0]  mouse_idx,
  input  logic        joy_en,
  input  logic [7:0]  joystick1,
  input  logic [7:0]  joystick2,
  input  logic [7:0]  joystick3,
  input  logic [7:0]  joystick4,
  output logic [15:0] joyana1,
  output logic [15:0] joyana2,
  output logic [15:0] joyana3,
  output logic [15:0] joyana4,
  output logic        win_commit
);

  // Three guard bits cover pending + joystick step + a full 9-bit mouse delta.
  localparam int                    c_w      = PEND_W + 3;
  localparam logic signed [c_w-1:0] c_lim_hi = c_w'(127);
  localparam logic signed [c_w-1:0] c_lim_lo = c_w'(-128);
  localparam logic signed [c_w-1:0] c_sat_hi = c_w'((1 << (PEND_W - 1)) - 1);
  localparam logic signed [c_w-1:0] c_sat_lo = -c_sat_hi;
  localparam logic signed [c_w-1:0] c_zero   = '0;
  localparam logic signed [c_w-1:0] c_step   = c_w'(JOY_STEP);

  logic                     r_lhbl_d;
  logic [5:0]               r_line;
  logic                     r_commit;
  logic signed [PEND_W-1:0] r_pend [8];
  logic [7:0]               r_out  [8];

  logic signed [PEND_W-1:0] w_next [8];
  logic [7:0]               w_byte [8];
  logic [7:0]               w_joy  [4];
  logic                     w_edge;
  logic                     w_commit;
  logic signed [c_w-1:0]    w_mdx;
  logic signed [c_w-1:0]    w_dy_ext;
  logic signed [c_w-1:0]    w_mdy;
  logic                     w_unused_joy;

  assign w_joy[0] = joystick1;
  assign w_joy[1] = joystick2;
  assign w_joy[2] = joystick3;
  assign w_joy[3] = joystick4;
  assign w_unused_joy = &{joystick1[7:4], joystick2[7:4], joystick3[7:4], joystick4[7:4]};

  assign w_edge   = ~LHBL & r_lhbl_d;
  assign w_commit = w_edge & (r_line == 6'd63);

  assign w_mdx    = {{(c_w - 9){mouse_dx[8]}}, mouse_dx};
  assign w_dy_ext = {{(c_w - 9){mouse_dy[8]}}, mouse_dy};
  assign w_mdy    = INVERT_Y ? -w_dy_ext : w_dy_ext;

  // Axis index a = player*2 + (0 for X, 1 for Y).
  genvar a;
  generate
    for (a = 0; a < 8; a++) begin : g_axis
      localparam int c_p    = a / 2;
      localparam bit c_is_y = (a % 2) == 1;

      logic                  w_pos;
      logic                  w_neg;
      logic                  w_hit;
      logic signed [c_w-1:0] w_delta;
      logic signed [c_w-1:0] w_jterm;
      logic signed [c_w-1:0] w_base;
      logic signed [c_w-1:0] w_sum;
      logic signed [c_w-1:0] w_clamp;
      logic signed [c_w-1:0] w_acc;

      assign w_pos   = c_is_y ? ~w_joy[c_p][3] : ~w_joy[c_p][0];
      assign w_neg   = c_is_y ? ~w_joy[c_p][2] : ~w_joy[c_p][1];
      assign w_jterm = (!joy_en || !w_commit || (w_pos == w_neg)) ? c_zero
                     : (w_pos ? c_step : -c_step);
      assign w_delta = c_is_y ? w_mdy : w_mdx;
      assign w_hit   = mouse_strobe && (mouse_idx == 2'(c_p));

      assign w_base  = {{3{r_pend[a][PEND_W-1]}}, r_pend[a]};
      assign w_sum   = w_base + w_jterm;
      assign w_clamp = (w_sum > c_lim_hi) ? c_lim_hi
                     : (w_sum < c_lim_lo) ? c_lim_lo : w_sum;

      // A mouse delta landing on the commit cycle goes straight into the residue.
      assign w_acc   = (w_commit ? (w_sum - w_clamp) : w_base) + (w_hit ? w_delta : c_zero);

      assign w_next[a] = (w_acc > c_sat_hi) ? c_sat_hi[PEND_W-1:0]
                       : (w_acc < c_sat_lo) ? c_sat_lo[PEND_W-1:0]
                       : w_acc[PEND_W-1:0];
      assign w_byte[a] = w_clamp[7:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lhbl_d <= 1'b1;
      r_line   <= 6'd0;
      r_commit <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_pend[i] <= '0;
        r_out[i]  <= 8'd0;
      end
    end else begin
      r_lhbl_d <= LHBL;
      r_commit <= w_commit;
      if (w_edge) begin
        r_line <= r_line + 6'd1;
      end
      for (int i = 0; i < 8; i++) begin
        r_pend[i] <= w_next[i];
        if (w_commit) begin
          r_out[i] <= w_byte[i];
        end
      end
    end
  end

  assign joyana1    = {r_out[1], r_out[0]};
  assign joyana2    = {r_out[3], r_out[2]};
  assign joyana3    = {r_out[5], r_out[4]};
  assign joyana4    = {r_out[7], r_out[6]};
  assign win_commit = r_commit;

endmodule
`default_nettype wire

// File: tb/tb_jts16b_trackball_feed.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_jts16b_trackball_feed                                      |
// | Desc     : Directed self-checking bench for jts16b_trackball_feed.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_jts16b_trackball_feed;

  logic        rst;
  logic        clk;
  logic        LHBL;
  logic        mouse_strobe;
  logic [8:0]  mouse_dx;
  logic [8:0]  mouse_dy;
  logic [1:0]  mouse_idx;
  logic        joy_en;
  logic [7:0]  joystick1;
  logic [7:0]  joystick2;
  logic [7:0]  joystick3;
  logic [7:0]  joystick4;
  logic [15:0] joyana1;
  logic [15:0] joyana2;
  logic [15:0] joyana3;
  logic [15:0] joyana4;
  logic        win_commit;

  int n_checks  = 0;
  int n_pass    = 0;
  int n_commits = 0;
  int c0;

  jts16b_trackball_feed dut (
    .rst          (rst),
    .clk          (clk),
    .LHBL         (LHBL),
    .mouse_strobe (mouse_strobe),
    .mouse_dx     (mouse_dx),
    .mouse_dy     (mouse_dy),
    .mouse_idx    (mouse_idx),
    .joy_en       (joy_en),
    .joystick1    (joystick1),
    .joystick2    (joystick2),
    .joystick3    (joystick3),
    .joystick4    (joystick4),
    .joyana1      (joyana1),
    .joyana2      (joyana2),
    .joyana3      (joyana3),
    .joyana4      (joyana4),
    .win_commit   (win_commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (win_commit) n_commits++;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    LHBL = 1'b1;
    rst  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic mouse(input logic [8:0] dx, input logic [8:0] dy, input logic [1:0] idx);
    mouse_dx = dx; mouse_dy = dy; mouse_idx = idx; mouse_strobe = 1'b1;
    tick();
    mouse_strobe = 1'b0;
  endtask

  // One line: LHBL high two cycles, then falls; returns just after the edge clock.
  task automatic hline(input bit strobe, input logic [8:0] dx, input logic [1:0] idx);
    LHBL = 1'b1;
    tick();
    tick();
    LHBL = 1'b0;
    if (strobe) begin
      mouse_dx = dx; mouse_dy = 9'd0; mouse_idx = idx; mouse_strobe = 1'b1;
    end
    tick();
    mouse_strobe = 1'b0;
  endtask

  task automatic window(input bit strobe, input logic [8:0] dx, input logic [1:0] idx);
    repeat (63) hline(1'b0, 9'd0, 2'd0);
    hline(strobe, dx, idx);
  endtask

  initial begin
    rst = 1'b0; LHBL = 1'b1; mouse_strobe = 1'b0;
    mouse_dx = '0; mouse_dy = '0; mouse_idx = '0; joy_en = 1'b0;
    joystick1 = 8'hFF; joystick2 = 8'hFF; joystick3 = 8'hFF; joystick4 = 8'hFF;

    // Reset state and the first idle window
    LHBL = 1'b1; rst = 1'b1; tick();
    chk("rst_joyana1", joyana1, 16'h0000);
    chk("rst_joyana4", joyana4, 16'h0000);
    chk("rst_commit", {15'd0, win_commit}, 16'h0000);
    rst = 1'b0; tick();
    c0 = n_commits;
    repeat (63) hline(1'b0, 9'd0, 2'd0);
    chk("no_commit_before_64", 16'(n_commits - c0), 16'd0);
    hline(1'b0, 9'd0, 2'd0);
    chk("commit_at_64th_edge", {15'd0, win_commit}, 16'h0001);
    chk("idle_joyana2", joyana2, 16'h0000);
    chk("idle_joyana3", joyana3, 16'h0000);
    tick();
    chk("commit_one_cycle", {15'd0, win_commit}, 16'h0000);
    chk("one_commit_per_window", 16'(n_commits - c0), 16'd1);

    // dx=+10, dy=+5 to player 2 with inverted Y
    mouse(9'd10, 9'd5, 2'd1);
    chk("strobe_no_output_change", joyana2, 16'h0000);
    window(1'b0, 9'd0, 2'd0);
    chk("p2_mouse", joyana2, 16'hFB0A);
    chk("p1_untouched", joyana1, 16'h0000);
    window(1'b0, 9'd0, 2'd0);
    chk("p2_drained", joyana2, 16'h0000);

    // 4 x +100 to player 1: 400 = 127 + 127 + 127 + 19
    repeat (4) mouse(9'd100, 9'd0, 2'd0);
    window(1'b0, 9'd0, 2'd0); chk("p1_clamp_w1", joyana1, 16'h007F);
    window(1'b0, 9'd0, 2'd0); chk("p1_clamp_w2", joyana1, 16'h007F);
    window(1'b0, 9'd0, 2'd0); chk("p1_clamp_w3", joyana1, 16'h007F);
    window(1'b0, 9'd0, 2'd0); chk("p1_residue_w4", joyana1, 16'h0013);
    window(1'b0, 9'd0, 2'd0); chk("p1_empty_w5", joyana1, 16'h0000);

    // LHBL static while 200 x -255 saturate player 3 X at -2047
    do_reset();
    c0 = n_commits;
    repeat (200) mouse(9'h101, 9'd0, 2'd2);
    repeat (100) tick();
    chk("static_lhbl_no_commit", 16'(n_commits - c0), 16'd0);
    chk("static_lhbl_output", joyana3, 16'h0000);
    for (int k = 0; k < 15; k++) begin
      window(1'b0, 9'd0, 2'd0);
      chk("sat_drain_80", joyana3, 16'h0080);
    end
    window(1'b0, 9'd0, 2'd0); chk("sat_last_81", joyana3, 16'h0081);
    window(1'b0, 9'd0, 2'd0); chk("sat_empty", joyana3, 16'h0000);

    // Joystick fallback
    do_reset();
    joy_en = 1'b1;
    joystick3 = 8'hFE; joystick1 = 8'hFD; joystick4 = 8'hF7;
    window(1'b0, 9'd0, 2'd0);
    chk("joy_p3_right_w1", joyana3, 16'h0018);
    chk("joy_p1_left", joyana1, 16'h00E8);
    chk("joy_p4_up", joyana4, 16'h1800);
    joystick1 = 8'hFF; joystick4 = 8'hFB;
    window(1'b0, 9'd0, 2'd0);
    chk("joy_p3_right_w2", joyana3, 16'h0018);
    chk("joy_p1_released", joyana1, 16'h0000);
    chk("joy_p4_down", joyana4, 16'hE800);
    joystick3 = 8'hFC;
    window(1'b0, 9'd0, 2'd0);
    chk("joy_p3_both", joyana3, 16'h0000);
    joy_en = 1'b0;
    joystick3 = 8'hFE;
    window(1'b0, 9'd0, 2'd0);
    chk("joy_disabled", joyana3, 16'h0000);
    joystick3 = 8'hFF; joystick4 = 8'hFF;

    // Mouse packet in the commit cycle lands in the residue
    do_reset();
    mouse(9'd3, 9'd0, 2'd0);
    window(1'b1, 9'd7, 2'd0);
    chk("same_cycle_commit", joyana1, 16'h0003);
    window(1'b0, 9'd0, 2'd0);
    chk("same_cycle_residue", joyana1, 16'h0007);
    window(1'b0, 9'd0, 2'd0);
    chk("same_cycle_empty", joyana1, 16'h0000);

    // Reset mid-window discards residue and clears outputs at once
    do_reset();
    mouse(9'd200, 9'd0, 2'd3);
    window(1'b0, 9'd0, 2'd0);
    chk("p4_before_reset", joyana4, 16'h007F);
    repeat (10) hline(1'b0, 9'd0, 2'd0);
    rst = 1'b1;
    #1;
    chk("async_reset_output", joyana4, 16'h0000);
    LHBL = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    window(1'b0, 9'd0, 2'd0);
    chk("residue_discarded", joyana4, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
